// File: rtl/uart_rx_fifo_feeder_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   OVERSAMPLE      : baud ticks per serial bit
//   MID_SAMPLE      : tick index of the middle of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_fifo_feeder_baud_gen.sv
// baud_gen: free-running oversample tick generator, shared by rx and tx.
//   clk, reset : system clock, async active-high reset
//   dvsr       : tick period is dvsr+1 clk cycles
//   tick       : one-clk pulse each period
module baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] cnt_q, cnt_d;

    // >= rather than == so that lowering dvsr below the current count
    // wraps at once instead of running all the way round the counter.
    always_comb begin
        tick  = (cnt_q >= dvsr);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: UART receiver that writes straight into a FIFO.
//   clk, reset    : system clock, async active-high reset
//   rx            : raw serial line (idle high, asynchronous)
//   dvsr          : baud divisor, oversample tick every dvsr+1 clk
//   dout          : last received word (LSB first on the line)
//   rx_done_tick  : one-clk strobe per frame, FIFO write enable
//   frame_err     : stop bit was low for the frame last strobed
//   break_det     : line still held low after a framing error
module uart_rx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [DVSR_W-1:0] dvsr,
    output logic [DBIT-1:0]   dout,
    output logic              rx_done_tick,
    output logic              frame_err,
    output logic              break_det
);

    localparam logic [4:0] S_MID  = 5'(MID_SAMPLE);
    localparam logic [4:0] S_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [3:0] N_LAST = 4'(DBIT - 1);

    logic              tick;
    logic [1:0]        rx_sync_q;
    logic              rx_s;

    uart_rx_state_t    state_q, state_d;
    logic [4:0]        s_q, s_d;
    logic [3:0]        n_q, n_d;
    logic [DBIT-1:0]   shreg_q, shreg_d;
    logic              stop_bit_q, stop_bit_d;
    logic              stop_now;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              brk_q, brk_d;

    baud_gen #(.DVSR_W(DVSR_W)) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    // Two-stage synchroniser, reset to the idle (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_sync_q <= 2'b11;
        else       rx_sync_q <= {rx_sync_q[0], rx};
    end
    assign rx_s = rx_sync_q[1];

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        stop_bit_d = stop_bit_q;
        stop_now   = stop_bit_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;

        case (state_q)
            // Start detection is not tick-gated so the mid-bit point is
            // measured from the first clk the line is seen low.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + 4'd1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    // The stop level is taken mid-bit; with one stop bit
                    // that is also the final tick, so use it directly.
                    if (s_q == S_BIT) stop_now = rx_s;
                    stop_bit_d = stop_now;
                    if (s_q == S_STOP) begin
                        dout_d  = shreg_q;
                        ferr_d  = ~stop_now;
                        done_d  = 1'b1;
                        s_d     = '0;
                        state_d = stop_now ? IDLE : BREAK;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            // Hold off new start detection until the line recovers.
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        brk_d = (state_d == BREAK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            stop_bit_q <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            stop_bit_q <= stop_bit_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign break_det    = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed bench for uart_rx_fifo_feeder: a vector table of single frames
// at several divisors, plus hand sequences for glitch, break, back-to-back,
// mid-frame reset, and a 7-bit / 2-stop instance at dvsr=0.
module tb_uart_rx_fifo_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx, rx2;
    logic [10:0] dvsr, dvsr2;
    logic [7:0]  dout;
    logic [6:0]  dout2;
    logic        done, ferr, brk;
    logic        done2, ferr2, brk2;

    always #5 clk = ~clk;

    uart_rx_fifo_feeder #(.DBIT(8), .SB_TICK(16), .DVSR_W(11)) dut (
        .clk(clk), .reset(reset), .rx(rx), .dvsr(dvsr),
        .dout(dout), .rx_done_tick(done), .frame_err(ferr), .break_det(brk)
    );

    uart_rx_fifo_feeder #(.DBIT(7), .SB_TICK(32), .DVSR_W(11)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .dvsr(dvsr2),
        .dout(dout2), .rx_done_tick(done2), .frame_err(ferr2), .break_det(brk2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         n_strb = 0, n_strb2 = 0;
    int         last_t = 0, prev_t = 0, last_t2 = 0;
    logic [7:0] last_dout = '0, prev_dout = '0;
    logic       last_ferr = 1'b0, prev_ferr = 1'b0;
    logic [6:0] last_dout2 = '0;
    logic       last_ferr2 = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            prev_dout = last_dout; prev_ferr = last_ferr; prev_t = last_t;
            last_dout = dout;      last_ferr = ferr;      last_t = cyc;
            n_strb++;
        end
        if (done2 === 1'b1) begin
            last_dout2 = dout2; last_ferr2 = ferr2; last_t2 = cyc;
            n_strb2++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    int t_fall;

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx  = v;
    endtask

    // Drives start, nb data bits LSB first, then the stop level for stop_clk.
    task automatic send(input logic [8:0] d, input int nb, input logic stp,
                        input int bclk, input int stop_clk, input bit sel);
        t_fall = cyc;
        set_rx(sel, 1'b0);
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            set_rx(sel, d[i]);
            repeat (bclk) @(negedge clk);
        end
        set_rx(sel, stp);
        repeat (stop_clk) @(negedge clk);
    endtask

    typedef struct {
        logic [10:0] dv;
        logic [7:0]  d;
        logic        stp;
        logic [7:0]  exp_d;
        logic        exp_f;
    } vec_t;

    vec_t vt[6];

    initial begin
        int base, k, lat, lows;

        vt[0] = '{11'd3, 8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{11'd3, 8'h12, 1'b1, 8'h12, 1'b0};
        vt[2] = '{11'd0, 8'h01, 1'b1, 8'h01, 1'b0};
        vt[3] = '{11'd1, 8'hE6, 1'b1, 8'hE6, 1'b0};
        vt[4] = '{11'd3, 8'h5A, 1'b0, 8'h5A, 1'b1};
        vt[5] = '{11'd0, 8'h80, 1'b1, 8'h80, 1'b0};

        reset = 1'b1; rx = 1'b1; rx2 = 1'b1; dvsr = 11'd3; dvsr2 = 11'd0;
        repeat (3) @(negedge clk);
        check("reset dout", dout, 0);
        check("reset done", done, 0);
        check("reset ferr", ferr, 0);
        check("reset brk", brk, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Vector table: one frame each, latency window of +-1 tick.
        for (int i = 0; i < 6; i++) begin
            dvsr = vt[i].dv;
            k    = int'(vt[i].dv) + 1;
            repeat (4) @(negedge clk);
            base = n_strb;
            send({1'b0, vt[i].d}, 8, vt[i].stp, 16 * k, 16 * k, 1'b0);
            rx = 1'b1;
            repeat (40) @(negedge clk);
            check($sformatf("vec%0d strobes", i), n_strb, base + 1);
            check($sformatf("vec%0d dout", i), last_dout, vt[i].exp_d);
            check($sformatf("vec%0d ferr", i), last_ferr, vt[i].exp_f);
            lat = last_t - t_fall;
            check_rng($sformatf("vec%0d latency", i), lat, 151 * k + 2, 152 * k + 5);
        end

        // Short low pulse: start is rejected at mid-bit.
        dvsr = 11'd3;
        repeat (10) @(negedge clk);
        base = n_strb;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch no strobe", n_strb, base);
        send(9'h03C, 8, 1'b1, 64, 64, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("after glitch strobes", n_strb, base + 1);
        check("after glitch dout", last_dout, 8'h3C);

        // Framing error followed by a long break.
        base = n_strb;
        send(9'h055, 8, 1'b0, 64, 64, 1'b0);
        check("break strobes", n_strb, base + 1);
        check("break dout", last_dout, 8'h55);
        check("break ferr", last_ferr, 1);
        lows = 0;
        repeat (2000) begin
            @(negedge clk);
            if (brk !== 1'b1) lows++;
        end
        check("break_det held", lows, 0);
        check("break no retrigger", n_strb, base + 1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_det cleared", brk, 0);
        repeat (40) @(negedge clk);
        send(9'h012, 8, 1'b1, 64, 64, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("post-break dout", last_dout, 8'h12);
        check("post-break ferr", last_ferr, 0);

        // Back-to-back frames with no idle gap.
        base = n_strb;
        send(9'h000, 8, 1'b1, 64, 64, 1'b0);
        send(9'h0FF, 8, 1'b1, 64, 64, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("b2b strobes", n_strb, base + 2);
        check("b2b first dout", prev_dout, 8'h00);
        check("b2b first ferr", prev_ferr, 0);
        check("b2b second dout", last_dout, 8'hFF);
        check("b2b second ferr", last_ferr, 0);
        check_rng("b2b spacing", last_t - prev_t, 636, 644);

        // Reset during data bit 4 of 0xC3 (bits 1,1,0,0,0...).
        base = n_strb;
        rx = 1'b0; repeat (64) @(negedge clk);
        rx = 1'b1; repeat (128) @(negedge clk);
        rx = 1'b0; repeat (128) @(negedge clk);
        repeat (32) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset dout", dout, 0);
        check("midreset done", done, 0);
        check("midreset ferr", ferr, 0);
        check("midreset brk", brk, 0);
        rx = 1'b1;
        reset = 1'b0;
        repeat (700) @(negedge clk);
        check("midreset no strobe", n_strb, base);
        send(9'h081, 8, 1'b1, 64, 64, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("after reset strobes", n_strb, base + 1);
        check("after reset dout", last_dout, 8'h81);

        // 7 data bits, two stop bits, tick every clk.
        base = n_strb2;
        send(9'h05A, 7, 1'b1, 16, 32, 1'b1);
        rx2 = 1'b1;
        repeat (20) @(negedge clk);
        check("d7 strobes", n_strb2, base + 1);
        check("d7 dout", last_dout2, 7'h5A);
        check("d7 ferr", last_ferr2, 0);
        check("d7 latency", last_t2 - t_fall, 155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
- UART receive front-end sitting directly upstream of the FIFO controller.
- Synchronises the serial rx line and oversamples it 16x against an internal programmable baud tick.
- Deserialises LSB-first frames and emits one `rx_done_tick` pulse per frame, wired straight to the FIFO write strobe, with the byte on `dout`.
- Flags framing errors and suppresses re-triggering on a held-low (break) line.

Parameters:
- DBIT, 8: data bits per frame (5..9).
- SB_TICK, 16: stop-bit duration in oversample ticks (16 = 1 stop, 24 = 1.5, 32 = 2).
- DVSR_W, 11: width of baud divisor input.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  raw serial input, idle high, asynchronous to clk
- dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clk cycles
- dout  out  DBIT  last received data word
- rx_done_tick  out  1  one-cycle strobe, frame complete (drives FIFO wr)
- frame_err  out  1  stop bit sampled low for the frame reported by the current/last rx_done_tick
- break_det  out  1  high while the line is held low after a framing error

Behaviour:
- Reset (async, active-high): sync FFs=1, FSM=IDLE, s=0, n=0, shift reg=0, baud counter=0.
  - Outputs: `dout`=0, `rx_done_tick`=0, `frame_err`=0, `break_det`=0.
  - Reset mid-frame abandons the frame with no strobe.
- Input sync: 2-FF synchroniser on rx gives rx_s. Both stages reset to 1.
- Baud gen: counter 0..dvsr.
  - `tick`=1 for one clk when counter==dvsr, and the counter wraps to 0.
  - dvsr=0 gives a tick every cycle.
  - A dvsr change takes effect immediately; frame integrity across the change is not guaranteed.
- Counters: s = oversample count (5 bits, wide enough for SB_TICK-1); n = bit index.
- FSM states and transitions:
  - IDLE: on any clk with rx_s==0, go to START with s=0. Not gated by tick.
  - START: on tick, if s==7 (mid start bit):
    - rx_s==0: go to DATA, s=0, n=0.
    - rx_s==1: glitch; return to IDLE with no strobe.
    - Otherwise (s<7) s++.
  - DATA: on tick, if s==15:
    - Shift in: shreg={rx_s, shreg[DBIT-1:1]}, s=0.
    - If n==DBIT-1 go to STOP, else n++.
    - Otherwise s++.
  - STOP: on tick, s++.
    - At s==15, latch stop_bit=rx_s.
    - When s==SB_TICK-1: `dout`<=shreg, `frame_err`<=~stop_bit, `rx_done_tick`<=1.
    - Then go to BREAK if stop_bit==0, else IDLE.
  - BREAK: `break_det`=1; go to IDLE on the first clk with rx_s==1.
- Output timing:
  - `rx_done_tick` is registered and high exactly one clk.
  - `dout` and `frame_err` are valid in the same cycle and hold until the next strobe.
- Latency, rx falling edge to strobe: 2 sync cycles + (7 + 16*DBIT + SB_TICK) ticks, ±1 tick of phase uncertainty.
- No backpressure: a strobe while the FIFO is full is dropped downstream. This block never stalls.
- Framing-errored frames are still delivered (strobe + `frame_err`=1); the consumer decides.
- Back-to-back frames: returning to IDLE mid-stop-bit (SB_TICK=16) allows a start edge immediately after stop, with no lost frame.

Decomposition:
- Package `uart_pkg`:
  - typedef enum `uart_rx_state_t` {IDLE, START, DATA, STOP, BREAK}.
  - Constants OVERSAMPLE=16, MID_SAMPLE=7.
- Sub-module `baud_gen` (params DVSR_W; ports clk, reset, dvsr, tick), instantiated once.
  - Reusable by the future uart_tx downstream of the FIFO.

Test Plan:
- dvsr=3 (tick/4 clk, bit=64 clk), send 8N1 0xA5 -> single `rx_done_tick`, `dout`=8'hA5, `frame_err`=0, strobe ~610 clk after rx falls.
- rx low 12 clk then high, then frame 0x3C -> no strobe for glitch; one strobe with `dout`=8'h3C.
- Frame 0x55 with stop bit 0, rx held low 2000 clk -> one strobe, `dout`=8'h55, `frame_err`=1, `break_det`=1 throughout, no further strobes; rx high then frame 0x12 -> `dout`=8'h12, `frame_err`=0.
- Back-to-back 0x00 then 0xFF, no idle gap -> two strobes ~640 clk apart, values correct, `frame_err`=0 both.
- Reset pulsed during data bit 4 of 0xC3, then frame 0x81 -> no strobe for 0xC3, all outputs 0 during reset, then `dout`=8'h81.
- Instance DBIT=7, SB_TICK=32, dvsr=0, send 7-bit 0x5A with 2 stop bits -> `dout`=7'h5A, `frame_err`=0; strobe at stop-tick 31.
